// File: rtl/spio_uart_tx_arb.sv
// Two-requester message arbiter in front of a UART transmitter.
// Each granted message is optionally prefixed with a per-source header byte.
module spio_uart_tx_arb #(
  parameter bit          HDR_EN  = 1'b1,
  parameter logic [7:0]  HDR0    = 8'hA0,
  parameter logic [7:0]  HDR1    = 8'hA1,
  parameter int          TIMEOUT = 1024
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic [7:0] DATA0_IN,
  input  logic       LAST0_IN,
  input  logic       VLD0_IN,
  output logic       RDY0_OUT,
  input  logic [7:0] DATA1_IN,
  input  logic       LAST1_IN,
  input  logic       VLD1_IN,
  output logic       RDY1_OUT,
  output logic [7:0] DATA_OUT,
  output logic       VLD_OUT,
  input  logic       RDY_IN,
  output logic       TIMEOUT_OUT
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  state_t        state;
  logic          g, p;
  logic [CW-1:0] cnt;

  logic       free, vld_g, last_g, xfer, tmo_hit;
  logic [7:0] data_g;

  assign free   = !VLD_OUT || RDY_IN;
  assign vld_g  = g ? VLD1_IN  : VLD0_IN;
  assign last_g = g ? LAST1_IN : LAST0_IN;
  assign data_g = g ? DATA1_IN : DATA0_IN;
  assign xfer   = (state == BODY) && vld_g && free;

  assign RDY0_OUT = (state == BODY) && !g && free;
  assign RDY1_OUT = (state == BODY) &&  g && free;

  // Abort fires on the idle cycle that brings the count up to TIMEOUT.
  assign tmo_hit = (TIMEOUT != 0) && (state == BODY) && !vld_g &&
                   (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state       <= IDLE;
      g           <= 1'b0;
      p           <= 1'b1;
      cnt         <= '0;
      DATA_OUT    <= '0;
      VLD_OUT     <= 1'b0;
      TIMEOUT_OUT <= 1'b0;
    end else begin
      TIMEOUT_OUT <= 1'b0;
      // Drain; a load below in the same cycle overrides this.
      if (VLD_OUT && RDY_IN) VLD_OUT <= 1'b0;
      case (state)
        IDLE: begin
          if (VLD0_IN || VLD1_IN) begin
            g     <= (VLD0_IN && VLD1_IN) ? !p : VLD1_IN;
            state <= HDR_EN ? HDR : BODY;
            cnt   <= '0;
          end
        end
        HDR: begin
          if (free) begin
            DATA_OUT <= g ? HDR1 : HDR0;
            VLD_OUT  <= 1'b1;
            state    <= BODY;
            cnt      <= '0;
          end
        end
        BODY: begin
          if (xfer) begin
            DATA_OUT <= data_g;
            VLD_OUT  <= 1'b1;
            cnt      <= '0;
            if (last_g) begin
              p     <= g;
              state <= IDLE;
            end
          end else if (!vld_g) begin
            if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
            if (tmo_hit) begin
              TIMEOUT_OUT <= 1'b1;
              p           <= g;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spio_uart_tx_arb.sv
// Directed bench: queue-driven requesters, output byte log compared to
// hand-written expected sequences; second instance covers HDR_EN=0.
module tb_spio_uart_tx_arb;

  logic       clk, rst, rdy;
  logic [7:0] d0, d1, dout;
  logic       l0, l1, v0, v1, rdy0, rdy1, vo, tmo;

  logic [7:0] b_d, b_do;
  logic       b_l, b_v, b_rdy0, b_rdy1, b_vo, b_tmo;

  spio_uart_tx_arb #(.HDR_EN(1'b1), .TIMEOUT(8)) dut (
    .CLK_IN(clk), .RESET_IN(rst),
    .DATA0_IN(d0), .LAST0_IN(l0), .VLD0_IN(v0), .RDY0_OUT(rdy0),
    .DATA1_IN(d1), .LAST1_IN(l1), .VLD1_IN(v1), .RDY1_OUT(rdy1),
    .DATA_OUT(dout), .VLD_OUT(vo), .RDY_IN(rdy), .TIMEOUT_OUT(tmo)
  );

  spio_uart_tx_arb #(.HDR_EN(1'b0), .TIMEOUT(8)) dut_nh (
    .CLK_IN(clk), .RESET_IN(rst),
    .DATA0_IN(b_d), .LAST0_IN(b_l), .VLD0_IN(b_v), .RDY0_OUT(b_rdy0),
    .DATA1_IN(8'h00), .LAST1_IN(1'b0), .VLD1_IN(1'b0), .RDY1_OUT(b_rdy1),
    .DATA_OUT(b_do), .VLD_OUT(b_vo), .RDY_IN(1'b1), .TIMEOUT_OUT(b_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] q0[$], q1[$];
  logic [7:0] lg[$], ex[$];
  bit         acc0, acc1, oacc;
  int         cyc, tmo_n, tmo_cyc, cyc0;
  int         n_chk, n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 200 && lg.size() < n; i++) tick(1);
    tick(3);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, lg.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < lg.size()) ? {24'h0, lg[i]} : 32'hffff_ffff, {24'h0, ex[i]});
  endtask

  // Requester drivers and output monitor; handshakes sampled mid-low-phase.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      v0 = q0.size() > 0;
      {l0, d0} = v0 ? q0[0] : 9'h0;
      v1 = q1.size() > 0;
      {l1, d1} = v1 ? q1[0] : 9'h0;
      #1;
      acc0 = v0 && rdy0;
      acc1 = v1 && rdy1;
      oacc = vo && rdy;
      if (oacc) lg.push_back(dout);
      if (tmo) begin tmo_n++; tmo_cyc = cyc; end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rdy = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; l0 = 1'b0; l1 = 1'b0;
    b_v = 1'b0; b_d = '0; b_l = 1'b0;
    tick(3);
    chk("rst_vld", vo, 1'b0);
    chk("rst_rdy0", rdy0, 1'b0);
    chk("rst_rdy1", rdy1, 1'b0);
    chk("rst_tmo", tmo, 1'b0);

    // Both requesters valid from reset; no-header instance sole-valid too.
    q0.push_back(9'h011); q0.push_back(9'h112);
    q1.push_back(9'h021); q1.push_back(9'h122);
    b_v = 1'b1; b_d = 8'h55; b_l = 1'b1;
    rdy = 1'b1;
    tick(2);
    chk("rst_rdy0_busy", rdy0, 1'b0);
    chk("nh_rst_rdy", b_rdy0, 1'b0);
    rst = 1'b0;
    tick(1);                      // edge t: IDLE -> BODY in no-header instance
    chk("nh_t_vld", b_vo, 1'b0);
    chk("nh_t_rdy", b_rdy0, 1'b1);
    tick(1);                      // edge t+1 loaded the byte, visible at t+2
    chk("nh_t2_vld", b_vo, 1'b1);
    chk("nh_t2_data", b_do, 8'h55);
    b_v = 1'b0; b_l = 1'b0;
    tick(1);
    chk("nh_drain", b_vo, 1'b0);
    chk("nh_rdy1", b_rdy1, 1'b0);
    chk("nh_tmo", b_tmo, 1'b0);

    wait_log(6);
    ex = '{8'hA0, 8'h11, 8'h12, 8'hA1, 8'h21, 8'h22};
    check_log("tie");

    // Fairness: r0 three 1-byte messages against a continuously valid r1.
    lg.delete();
    q0.push_back(9'h101); q0.push_back(9'h102); q0.push_back(9'h103);
    q1.push_back(9'h131); q1.push_back(9'h132); q1.push_back(9'h133); q1.push_back(9'h134);
    wait_log(14);
    ex = '{8'hA0, 8'h01, 8'hA1, 8'h31, 8'hA0, 8'h02, 8'hA1, 8'h32,
           8'hA0, 8'h03, 8'hA1, 8'h33, 8'hA1, 8'h34};
    check_log("rr");

    // Transmitter stall mid-body.
    lg.delete();
    q0.push_back(9'h041); q0.push_back(9'h042); q0.push_back(9'h043); q0.push_back(9'h144);
    for (int i = 0; i < 200 && lg.size() < 2; i++) tick(1);
    rdy = 1'b0;
    tick(10);
    chk("stall_vld", vo, 1'b1);
    chk("stall_data", dout, 8'h42);
    chk("stall_rdy0", rdy0, 1'b0);
    chk("stall_len", lg.size(), 2);
    rdy = 1'b1;
    wait_log(5);
    ex = '{8'hA0, 8'h41, 8'h42, 8'h43, 8'h44};
    check_log("stall");
    chk("no_tmo_yet", tmo_n, 0);

    // r0 stops mid-message; r1 arrives while r0 still holds the grant.
    lg.delete();
    cyc0 = cyc;
    q0.push_back(9'h051);
    tick(3);
    q1.push_back(9'h161);
    wait_log(4);
    chk("tmo_count", tmo_n, 1);
    chk("tmo_delay", tmo_cyc - cyc0, 12);
    ex = '{8'hA0, 8'h51, 8'hA1, 8'h61};
    check_log("tmo");

    // Serve r0 so the last-served pointer favours r1 before reset.
    lg.delete();
    q0.push_back(9'h171);
    wait_log(2);
    ex = '{8'hA0, 8'h71};
    check_log("pre");

    lg.delete();
    q1.push_back(9'h081); q1.push_back(9'h082); q1.push_back(9'h183);
    for (int i = 0; i < 200 && lg.size() < 2; i++) tick(1);
    chk("pre_rst_vld", vo, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", vo, 1'b0);
    chk("mid_rst_rdy1", rdy1, 1'b0);
    q0.delete(); q1.delete(); lg.delete();
    acc0 = 1'b0; acc1 = 1'b0; oacc = 1'b0;
    q0.push_back(9'h191); q1.push_back(9'h1E1);
    tick(2);
    rst = 1'b0;
    wait_log(4);
    ex = '{8'hA0, 8'h91, 8'hA1, 8'hE1};
    check_log("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
